// File: rtl/conv_layer_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_engine_pkg
//  Description : Shared widths, data types and FSM encoding for the layer-1
//                convolution engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_layer_engine_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;

    typedef logic        [DATA_W-1:0] pixel_t;
    typedef logic signed [DATA_W-1:0] weight_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        MAC    = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } conv_state_t;

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_engine_if
//  Description : Control handshake plus image / weight read ports and output
//                write port of the convolution engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_layer_engine_if
    import conv_layer_engine_pkg::*;
#(
    parameter int IN_AW  = 14,
    parameter int W_AW   = 9,
    parameter int OUT_AW = 18
);
    logic              start;
    logic              busy;
    logic              done;
    logic              in_rd;
    logic [IN_AW-1:0]  in_addr;
    pixel_t            in_data;
    logic              w_rd;
    logic [W_AW-1:0]   w_addr;
    weight_t           w_data;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    // Engine side
    modport master (
        input  start, in_data, w_data,
        output busy, done, in_rd, in_addr, w_rd, w_addr,
               out_we, out_addr, out_data
    );

    // Host / memory side
    modport slave (
        output start, in_data, w_data,
        input  busy, done, in_rd, in_addr, w_rd, w_addr,
               out_we, out_addr, out_data
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_engine_mac.sv
`default_nettype none
// ============================================================================
//  Module      : mac_unit
//  Description : Registered multiply-accumulate of an unsigned pixel with a
//                signed weight; clr restarts the sum, en adds one product.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_unit
    import conv_layer_engine_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clr,
    input  wire logic               en,
    input  wire pixel_t             pixel,
    input  wire weight_t            weight,
    output logic signed [ACC_W-1:0] acc
);

    // Pixel is zero-extended to 9 bits so the product stays a signed 17-bit value.
    logic signed [2*DATA_W:0] w_prod;

    assign w_prod = $signed({1'b0, pixel}) * weight;

    // Accumulator register: clear takes priority over accumulate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(w_prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_engine
//  Description : Sequential single-channel 2-D convolution (stride 1, no
//                padding), one MAC per cycle, ReLU + shift + saturation to
//                0..127, results written in ascending output address order.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_engine
    import conv_layer_engine_pkg::*;
#(
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int K        = 5,
    parameter int NUM_FILT = 16,
    parameter int SHIFT    = 8
)(
    input  wire logic           clk,
    input  wire logic           reset,
    conv_layer_engine_if.master bus
);

    localparam int c_OUT_W  = IMG_W - K + 1;
    localparam int c_OUT_H  = IMG_H - K + 1;
    localparam int c_KK     = K * K;
    localparam int c_IN_AW  = clog2_min1(IMG_W * IMG_H);
    localparam int c_W_AW   = clog2_min1(NUM_FILT * c_KK);
    localparam int c_OUT_AW = clog2_min1(NUM_FILT * c_OUT_W * c_OUT_H);
    localparam int c_TAP_W  = clog2_min1(c_KK + 1);
    localparam int c_K_W    = clog2_min1(K + 1);
    localparam int c_X_W    = clog2_min1(c_OUT_W);
    localparam int c_Y_W    = clog2_min1(c_OUT_H);
    localparam int c_F_W    = clog2_min1(NUM_FILT);

    localparam logic [c_TAP_W-1:0] c_TAP_LAST = c_TAP_W'(c_KK);
    localparam logic [c_TAP_W-1:0] c_TAP_ONE  = c_TAP_W'(1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(K - 1);
    localparam logic [c_K_W-1:0]   c_K_ONE    = c_K_W'(1);
    localparam logic [c_X_W-1:0]   c_X_LAST   = c_X_W'(c_OUT_W - 1);
    localparam logic [c_X_W-1:0]   c_X_ONE    = c_X_W'(1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST   = c_Y_W'(c_OUT_H - 1);
    localparam logic [c_Y_W-1:0]   c_Y_ONE    = c_Y_W'(1);
    localparam logic [c_F_W-1:0]   c_F_LAST   = c_F_W'(NUM_FILT - 1);
    localparam logic [c_F_W-1:0]   c_F_ONE    = c_F_W'(1);
    localparam logic signed [ACC_W-1:0] c_QMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [c_F_W-1:0]   r_f;
    logic [c_Y_W-1:0]   r_oy;
    logic [c_X_W-1:0]   r_ox;
    logic [c_K_W-1:0]   r_ky;
    logic [c_K_W-1:0]   r_kx;
    logic [c_TAP_W-1:0] r_tap;
    weight_t            r_wreg [c_KK];

    logic [c_TAP_W-1:0]       w_tap_prev;
    logic                     w_tap_last;
    logic                     w_pix_last;
    logic                     w_filt_last;
    weight_t                  w_wsel;
    logic                     w_mac_clr;
    logic                     w_mac_en;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [DATA_W-1:0]        w_q_data;

    // Data returned by a read belongs to the tap issued one cycle earlier.
    assign w_tap_prev  = r_tap - c_TAP_ONE;
    assign w_tap_last  = (r_tap == c_TAP_LAST);
    assign w_pix_last  = (r_ox == c_X_LAST) && (r_oy == c_Y_LAST);
    assign w_filt_last = (r_f == c_F_LAST);
    assign w_wsel      = r_wreg[w_tap_prev];
    assign w_mac_clr   = (r_state == MAC) && (r_tap == '0);
    assign w_mac_en    = (r_state == MAC) && (r_tap != '0);

    mac_unit u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_mac_clr),
        .en     (w_mac_en),
        .pixel  (bus.in_data),
        .weight (w_wsel),
        .acc    (w_acc)
    );

    // ReLU, arithmetic shift and saturation of the finished sum.
    assign w_shifted = w_acc >>> SHIFT;
    assign w_q_data  = w_acc[ACC_W-1]      ? '0 :
                       (w_shifted > c_QMAX) ? c_QMAX[DATA_W-1:0] :
                                              w_shifted[DATA_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and output strobes/addresses.
    always_comb begin
        w_state_nxt  = r_state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.in_rd    = 1'b0;
        bus.in_addr  = '0;
        bus.w_rd     = 1'b0;
        bus.w_addr   = '0;
        bus.out_we   = 1'b0;
        bus.out_addr = '0;
        bus.out_data = '0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                bus.busy = 1'b1;
                if (w_tap_last) begin
                    w_state_nxt = MAC;
                end else begin
                    bus.w_rd   = 1'b1;
                    bus.w_addr = c_W_AW'(r_f) * c_W_AW'(c_KK) + c_W_AW'(r_tap);
                end
            end
            MAC: begin
                bus.busy = 1'b1;
                if (w_tap_last) begin
                    w_state_nxt = WRITE;
                end else begin
                    bus.in_rd   = 1'b1;
                    bus.in_addr = (c_IN_AW'(r_oy) + c_IN_AW'(r_ky)) * c_IN_AW'(IMG_W)
                                + c_IN_AW'(r_ox) + c_IN_AW'(r_kx);
                end
            end
            WRITE: begin
                bus.busy     = 1'b1;
                bus.out_we   = 1'b1;
                bus.out_addr = c_OUT_AW'(r_f) * c_OUT_AW'(c_OUT_W * c_OUT_H)
                             + c_OUT_AW'(r_oy) * c_OUT_AW'(c_OUT_W)
                             + c_OUT_AW'(r_ox);
                bus.out_data = w_q_data;
                if (w_pix_last) begin
                    w_state_nxt = w_filt_last ? DONE : LOAD_W;
                end else begin
                    w_state_nxt = MAC;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Loop counters (filter, output pixel, kernel tap) and weight register file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_f   <= '0;
            r_oy  <= '0;
            r_ox  <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
            r_tap <= '0;
            for (int i = 0; i < c_KK; i++) begin
                r_wreg[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_f   <= '0;
                        r_oy  <= '0;
                        r_ox  <= '0;
                        r_ky  <= '0;
                        r_kx  <= '0;
                        r_tap <= '0;
                    end
                end
                LOAD_W: begin
                    if (r_tap != '0) begin
                        r_wreg[w_tap_prev] <= bus.w_data;
                    end
                    if (w_tap_last) begin
                        r_tap <= '0;
                        r_kx  <= '0;
                        r_ky  <= '0;
                    end else begin
                        r_tap <= r_tap + c_TAP_ONE;
                    end
                end
                MAC: begin
                    if (w_tap_last) begin
                        r_tap <= '0;
                        r_kx  <= '0;
                        r_ky  <= '0;
                    end else begin
                        r_tap <= r_tap + c_TAP_ONE;
                        if (r_kx == c_K_LAST) begin
                            r_kx <= '0;
                            r_ky <= r_ky + c_K_ONE;
                        end else begin
                            r_kx <= r_kx + c_K_ONE;
                        end
                    end
                end
                WRITE: begin
                    r_tap <= '0;
                    if (r_ox == c_X_LAST) begin
                        r_ox <= '0;
                        if (r_oy == c_Y_LAST) begin
                            r_oy <= '0;
                            r_f  <= w_filt_last ? '0 : (r_f + c_F_ONE);
                        end else begin
                            r_oy <= r_oy + c_Y_ONE;
                        end
                    end else begin
                        r_ox <= r_ox + c_X_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_engine
//  Description : Self-checking bench for conv_layer_engine (6x6 image, 3x3
//                kernel, 2 filters, no shift -> 32 output writes per run).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_engine;
    import conv_layer_engine_pkg::*;

    localparam int IMG_W    = 6;
    localparam int IMG_H    = 6;
    localparam int K        = 3;
    localparam int NUM_FILT = 2;
    localparam int SHIFT    = 0;
    localparam int OUT_W    = 4;
    localparam int OUT_H    = 4;
    localparam int N_OUT    = 32;
    localparam int LATENCY  = 373;
    localparam int BOUND    = 2000;

    typedef struct {
        int pix;
        int wt;
        int exp_data;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    conv_layer_engine_if #(.IN_AW(6), .W_AW(5), .OUT_AW(5)) bus ();

    conv_layer_engine #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .K        (K),
        .NUM_FILT (NUM_FILT),
        .SHIFT    (SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] img_mem [IMG_W*IMG_H];
    logic [7:0] w_mem   [NUM_FILT*K*K];

    // 1-cycle-latency read ports; junk is returned when no read was issued.
    always @(posedge clk) begin
        bus.in_data <= bus.in_rd ? img_mem[bus.in_addr] : 8'hA5;
        bus.w_data  <= bus.w_rd  ? $signed(w_mem[bus.w_addr]) : 8'sh5A;
    end

    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_writes;
    int   n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and monitor the DUT outputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        check("strobe_excl",
              ((int'(bus.in_rd) + int'(bus.w_rd) + int'(bus.out_we)) <= 1), 1);
        if (bus.out_we) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", bus.out_addr, e.addr);
                check("wr_data", bus.out_data, e.data);
            end
        end
        if (bus.done) n_done++;
    endtask

    // Reference convolution with ReLU, shift and saturation.
    function automatic int model(input int f, input int oy, input int ox);
        int acc = 0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                acc += int'(img_mem[(oy + ky) * IMG_W + ox + kx])
                     * int'($signed(w_mem[f * K * K + ky * K + kx]));
            end
        end
        if (acc < 0) return 0;
        acc = acc >>> SHIFT;
        return (acc > 127) ? 127 : acc;
    endfunction

    task automatic fill_const(input int pix, input int wt);
        for (int i = 0; i < IMG_W*IMG_H; i++) img_mem[i] = 8'(pix);
        for (int i = 0; i < NUM_FILT*K*K; i++) w_mem[i] = 8'(wt);
    endtask

    task automatic push_const(input int d);
        exp_t e;
        for (int i = 0; i < N_OUT; i++) begin
            e.addr = 5'(i);
            e.data = 8'(d);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_model();
        exp_t e;
        for (int f = 0; f < NUM_FILT; f++)
            for (int oy = 0; oy < OUT_H; oy++)
                for (int ox = 0; ox < OUT_W; ox++) begin
                    e.addr = 5'(f * OUT_W * OUT_H + oy * OUT_W + ox);
                    e.data = 8'(model(f, oy, ox));
                    sb_q.push_back(e);
                end
    endtask

    // Full run from a falling edge; optional stray start pulse at cycle pulse_at.
    task automatic run_layer(input string name, input int pulse_at);
        int lat;
        n_writes  = 0;
        n_done    = 0;
        bus.start = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < BOUND) begin
            tick();
            lat++;
            if (lat == 1) begin
                bus.start = 1'b0;
                check({name, "_busy_after_start"}, bus.busy, 1);
            end
            if (lat == pulse_at)     bus.start = 1'b1;
            if (lat == pulse_at + 1) bus.start = 1'b0;
            if (bus.done) break;
        end
        check({name, "_latency"}, lat, LATENCY);
        check({name, "_busy_in_done"}, bus.busy, 0);
        check({name, "_writes"}, n_writes, N_OUT);
        check({name, "_sb_empty"}, sb_q.size(), 0);
        tick();
        check({name, "_done_pulse_width"}, bus.done, 0);
        check({name, "_idle_busy"}, bus.busy, 0);
        check({name, "_done_count"}, n_done, 1);
        sb_q.delete();
    endtask

    vec_t vecs [3];

    initial begin
        vecs[0] = '{pix: 1,   wt: 1,   exp_data: 9};
        vecs[1] = '{pix: 10,  wt: -1,  exp_data: 0};
        vecs[2] = '{pix: 255, wt: 127, exp_data: 127};

        bus.start = 1'b0;
        fill_const(0, 0);
        n_writes = 0;
        n_done   = 0;

        // Reset state
        repeat (3) tick();
        check("rst_busy",   bus.busy,   0);
        check("rst_done",   bus.done,   0);
        check("rst_in_rd",  bus.in_rd,  0);
        check("rst_w_rd",   bus.w_rd,   0);
        check("rst_out_we", bus.out_we, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Uniform image/weight vectors
        for (int v = 0; v < 3; v++) begin
            fill_const(vecs[v].pix, vecs[v].wt);
            push_const(vecs[v].exp_data);
            run_layer($sformatf("vec%0d", v), -10);
            repeat (2) tick();
        end

        // Pixel = address, filter 0 centre tap only, filter 1 all zero
        for (int i = 0; i < IMG_W*IMG_H; i++) img_mem[i] = 8'(i);
        for (int i = 0; i < NUM_FILT*K*K; i++) w_mem[i] = 8'd0;
        w_mem[4] = 8'd1;
        push_model();
        run_layer("centre_tap", -10);
        repeat (2) tick();

        // Reset 50 cycles into a run, then restart
        fill_const(1, 1);
        push_const(9);
        n_writes  = 0;
        n_done    = 0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        tick();
        check("abort_busy",   bus.busy,   0);
        check("abort_in_rd",  bus.in_rd,  0);
        check("abort_w_rd",   bus.w_rd,   0);
        check("abort_out_we", bus.out_we, 0);
        check("abort_done",   bus.done,   0);
        check("abort_writes_before", n_writes, 3);
        reset = 1'b1;
        sb_q.delete();
        repeat (5) tick();
        check("abort_no_done", n_done, 0);
        push_const(9);
        run_layer("restart", -10);
        repeat (2) tick();

        // Stray start pulse while busy
        push_const(9);
        run_layer("start_ignored", 20);
        repeat (3) tick();
        check("final_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
